// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: writeback sequencer for a 16 x 16-bit register file.
// Full writes go straight to WRITE. LLB/LHB ops first read the old value
// through port 2 in READ, merge one byte, and then write it back in WRITE.
// R0 is never written. A reserved op is accepted, flagged on op_err one
// cycle later, and dropped.
// Optional feature macro: WB_BYPASS_EN drives byp_* with the in-flight write
// for forwarding. Without it, byp_* are tied to 0.
//
// state | meaning
// IDLE  | no pending request, ready to accept
// READ  | half op: old value read on port 2, byte merge captured
// WRITE | captured value driven on wr_data, one-hot wr_en; ready to accept
module regfile_write_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_reg,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_op,
    output logic [15:0] rd_en,
    input  logic [15:0] rd_data,
    output logic [15:0] wr_en,
    output logic [15:0] wr_data,
    output logic        load_half,
    output logic        op_err,
    output logic        byp_valid,
    output logic [3:0]  byp_reg,
    output logic [15:0] byp_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [1:0] OP_FULL = 2'b00;
    localparam logic [1:0] OP_LLB  = 2'b01;
    localparam logic [1:0] OP_LHB  = 2'b10;

    state_t      state, state_nxt;
    logic        accept;
    logic [3:0]  cap_reg;
    logic [1:0]  cap_op;
    logic [15:0] cap_val;
    logic [15:0] reg_onehot;
    logic [15:0] merged;

    // State register; reset drops any pending request before it can write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, handshake and register-file strobes.
    always_comb begin
        state_nxt  = state;
        in_ready   = rst && (state != READ);
        accept     = in_valid && in_ready;
        reg_onehot = 16'h0001 << cap_reg;
        rd_en      = 16'h0000;
        wr_en      = 16'h0000;
        wr_data    = 16'h0000;
        load_half  = 1'b0;
        // LLB keeps the old high byte, LHB keeps the old low byte.
        merged     = (cap_op == OP_LLB) ? {rd_data[15:8], cap_val[7:0]}
                                        : {cap_val[7:0], rd_data[7:0]};
        case (state)
            IDLE, WRITE: begin
                if (state == WRITE) begin
                    wr_en     = (cap_reg != 4'd0) ? reg_onehot : 16'h0000;
                    wr_data   = cap_val;
                    load_half = (cap_op != OP_FULL);
                end
                if (accept) begin
                    case (in_op)
                        OP_FULL:        state_nxt = WRITE;
                        OP_LLB, OP_LHB: state_nxt = READ;
                        default:        state_nxt = IDLE;
                    endcase
                end else begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                rd_en     = reg_onehot;
                state_nxt = WRITE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture on acceptance; half ops replace the value with the merge in READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_reg <= 4'd0;
            cap_op  <= OP_FULL;
            cap_val <= 16'h0000;
        end else if (accept) begin
            cap_reg <= in_reg;
            cap_op  <= in_op;
            cap_val <= in_data;
        end else if (state == READ) begin
            cap_val <= merged;
        end
    end

    // One-cycle error pulse following acceptance of a reserved op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) op_err <= 1'b0;
        else      op_err <= accept && (in_op == 2'b11);
    end

`ifdef WB_BYPASS_EN
    // READ only ever holds half ops, whose final value is not known yet, so
    // forwarding is valid only in WRITE.
    assign byp_valid = (state == WRITE) && (cap_reg != 4'd0);
    assign byp_reg   = byp_valid ? cap_reg : 4'd0;
    assign byp_data  = byp_valid ? cap_val : 16'h0000;
`else
    assign byp_valid = 1'b0;
    assign byp_reg   = 4'd0;
    assign byp_data  = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Bench for regfile_write_ctrl: directed scenarios plus a randomized run
// scored against a register-array model that applies requests in order.
module tb_regfile_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_reg;
    logic [15:0] in_data;
    logic [1:0]  in_op;
    logic [15:0] rd_en;
    logic [15:0] rd_data;
    logic [15:0] wr_en;
    logic [15:0] wr_data;
    logic        load_half;
    logic        op_err;
    logic        byp_valid;
    logic [3:0]  byp_reg;
    logic [15:0] byp_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf     [16];
    logic [15:0] exp_rf [16];

    typedef struct {
        logic [3:0]  r;
        logic [15:0] v;
        logic        h;
    } wr_t;
    wr_t exp_q[$];
    int  exp_err;
    int  seen_err;

    regfile_write_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .in_op(in_op),
        .rd_en(rd_en), .rd_data(rd_data),
        .wr_en(wr_en), .wr_data(wr_data),
        .load_half(load_half), .op_err(op_err),
        .byp_valid(byp_valid), .byp_reg(byp_reg), .byp_data(byp_data)
    );

    always #5 clk = ~clk;

    // Register array: known pattern while in reset, written by wr_en otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (!rst)          rf[i] <= (16'(i) * 16'h1111) ^ 16'h5A5A;
            else if (wr_en[i]) rf[i] <= wr_data;
        end
    end

    // Port-2 bitlines: OR of all enabled registers.
    always_comb begin
        rd_data = 16'h0000;
        for (int i = 0; i < 16; i++)
            if (rd_en[i]) rd_data = rd_data | rf[i];
    end

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_reg = 4'd0; in_data = 16'h0; in_op = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({wr_en, rd_en, wr_data} !== 48'h0) begin
            errors++; $display("FAIL reset_strobes: wr_en=%h rd_en=%h wr_data=%h expected 0", wr_en, rd_en, wr_data);
        end
        checks++;
        if ({load_half, op_err, byp_valid, byp_reg, byp_data} !== 23'h0) begin
            errors++; $display("FAIL reset_misc: lh=%b err=%b bv=%b br=%h bd=%h expected 0",
                               load_half, op_err, byp_valid, byp_reg, byp_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_full_write();
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_reg = 4'd5; in_data = 16'hBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 16'h0020 || wr_data !== 16'hBEEF || load_half !== 1'b0) begin
            errors++; $display("FAIL full_write: wr_en=%h wr_data=%h lh=%b expected 0020 BEEF 0", wr_en, wr_data, load_half);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 16'h0000) begin
            errors++; $display("FAIL full_write_single: wr_en=%h expected 0000", wr_en);
        end
    endtask

    task automatic test_lhb();
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_reg = 4'd3; in_data = 16'h1234;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b10; in_reg = 4'd3; in_data = 16'h00AB;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (rd_en !== 16'h0008 || in_ready !== 1'b0 || wr_en !== 16'h0000) begin
            errors++; $display("FAIL lhb_read: rd_en=%h in_ready=%b wr_en=%h expected 0008 0 0000", rd_en, in_ready, wr_en);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 16'h0008 || wr_data !== 16'hAB34 || load_half !== 1'b1 || rd_en !== 16'h0000) begin
            errors++; $display("FAIL lhb_write: wr_en=%h wr_data=%h lh=%b rd_en=%h expected 0008 AB34 1 0000",
                               wr_en, wr_data, load_half, rd_en);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_reg = 4'd1; in_data = 16'h1357;
        @(negedge clk);
        checks++;
        if (wr_en !== 16'h0002 || wr_data !== 16'h1357 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_first: wr_en=%h wr_data=%h rdy=%b expected 0002 1357 1", wr_en, wr_data, in_ready);
        end
        in_reg = 4'd2; in_data = 16'h2468;
        @(negedge clk);
        checks++;
        if (wr_en !== 16'h0004 || wr_data !== 16'h2468 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_second: wr_en=%h wr_data=%h rdy=%b expected 0004 2468 1", wr_en, wr_data, in_ready);
        end
        // LLB to the register being written this very cycle must see the new value.
        in_op = 2'b01; in_reg = 4'd2; in_data = 16'h00CD;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (rd_en !== 16'h0004 || wr_en !== 16'h0000) begin
            errors++; $display("FAIL raw_read: rd_en=%h wr_en=%h expected 0004 0000", rd_en, wr_en);
        end
        @(negedge clk);
        checks++;
        if (wr_en !== 16'h0004 || wr_data !== 16'h24CD || load_half !== 1'b1) begin
            errors++; $display("FAIL raw_llb: wr_en=%h wr_data=%h lh=%b expected 0004 24CD 1", wr_en, wr_data, load_half);
        end
    endtask

    task automatic test_r0_reserved();
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_reg = 4'd0; in_data = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (wr_en !== 16'h0000 || in_ready !== 1'b1) begin
            errors++; $display("FAIL r0_write: wr_en=%h rdy=%b expected 0000 1", wr_en, in_ready);
        end
        in_op = 2'b11; in_reg = 4'd4; in_data = 16'h7777;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (op_err !== 1'b1 || wr_en !== 16'h0000 || rd_en !== 16'h0000) begin
            errors++; $display("FAIL rsv_pulse: op_err=%b wr_en=%h rd_en=%h expected 1 0000 0000", op_err, wr_en, rd_en);
        end
        @(negedge clk);
        checks++;
        if (op_err !== 1'b0 || wr_en !== 16'h0000 || rd_en !== 16'h0000) begin
            errors++; $display("FAIL rsv_after: op_err=%b wr_en=%h rd_en=%h expected 0 0000 0000", op_err, wr_en, rd_en);
        end
        checks++;
        if (rf[0] !== 16'h5A5A || rf[4] !== 16'h1E1E) begin
            errors++; $display("FAIL r0_rsv_untouched: r0=%h r4=%h expected 5A5A 1E1E", rf[0], rf[4]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_reg = 4'd6; in_data = 16'h0077;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (rd_en !== 16'h0040) begin
            errors++; $display("FAIL mid_read: rd_en=%h expected 0040", rd_en);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({wr_en, rd_en, wr_data, load_half, op_err, byp_valid, byp_reg, byp_data, in_ready} !== 72'h0) begin
            errors++; $display("FAIL mid_reset_outputs: wr_en=%h rd_en=%h wr_data=%h lh=%b err=%b bv=%b rdy=%b expected all 0",
                               wr_en, rd_en, wr_data, load_half, op_err, byp_valid, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (wr_en !== 16'h0000 || rd_en !== 16'h0000 || in_ready !== 1'b1) begin
                errors++; $display("FAIL mid_after_release[%0d]: wr_en=%h rd_en=%h rdy=%b expected 0000 0000 1",
                                   k, wr_en, rd_en, in_ready);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bypass();
        logic        e_bv;
        logic [3:0]  e_br;
        logic [15:0] e_bd;
`ifdef WB_BYPASS_EN
        e_bv = 1'b1; e_br = 4'd7; e_bd = 16'h0F0F;
`else
        e_bv = 1'b0; e_br = 4'd0; e_bd = 16'h0000;
`endif
        in_valid = 1'b1; in_op = 2'b00; in_reg = 4'd7; in_data = 16'h0F0F;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 16'h0080 || byp_valid !== e_bv || byp_reg !== e_br || byp_data !== e_bd) begin
            errors++; $display("FAIL bypass: wr_en=%h bv=%b br=%h bd=%h expected 0080 %b %h %h",
                               wr_en, byp_valid, byp_reg, byp_data, e_bv, e_br, e_bd);
        end
        @(negedge clk);
        checks++;
        if (byp_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_idle: bv=%b expected 0", byp_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];
        exp_q.delete();
        exp_err  = 0;
        seen_err = 0;
        fork
            begin : driver
                for (int n = 0; n < 200; n++) begin
                    @(negedge clk);
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_reg   = 4'($urandom_range(0, 15));
                    in_data  = 16'($urandom);
                    in_op    = 2'($urandom_range(0, 3));
                    if (in_valid && in_ready) begin
                        wr_t w;
                        w.r = in_reg;
                        w.h = (in_op == 2'b01 || in_op == 2'b10);
                        case (in_op)
                            2'b00:   w.v = in_data;
                            2'b01:   w.v = {exp_rf[in_reg][15:8], in_data[7:0]};
                            2'b10:   w.v = {in_data[7:0], exp_rf[in_reg][7:0]};
                            default: w.v = 16'h0000;
                        endcase
                        if (in_op == 2'b11) exp_err++;
                        else if (in_reg != 4'd0) begin
                            exp_rf[in_reg] = w.v;
                            exp_q.push_back(w);
                        end
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
                repeat (5) @(negedge clk);
            end
            begin : monitor
                for (int n = 0; n < 212; n++) begin
                    @(negedge clk);
                    if (wr_en !== 16'h0000) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL rand_unexpected_write: wr_en=%h wr_data=%h expected no write", wr_en, wr_data);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            if (wr_en !== (16'h0001 << e.r) || wr_data !== e.v || load_half !== e.h) begin
                                errors++; $display("FAIL rand_write: wr_en=%h wr_data=%h lh=%b expected %h %h %b",
                                                   wr_en, wr_data, load_half, 16'h0001 << e.r, e.v, e.h);
                            end
                        end
                    end
                    if (rd_en !== 16'h0000) begin
                        checks++;
                        if (wr_en !== 16'h0000 || in_ready !== 1'b0) begin
                            errors++; $display("FAIL rand_read_excl: rd_en=%h wr_en=%h rdy=%b expected wr_en 0000 rdy 0",
                                               rd_en, wr_en, in_ready);
                        end
                    end
                    if (op_err === 1'b1) seen_err++;
                end
            end
        join
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_missing_writes: got %0d outstanding expected 0", exp_q.size());
        end
        checks++;
        if (seen_err != exp_err) begin
            errors++; $display("FAIL rand_op_err: got %0d pulses expected %0d", seen_err, exp_err);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rf[i] !== exp_rf[i]) begin
                errors++; $display("FAIL rand_rf[%0d]: got %h expected %h", i, rf[i], exp_rf[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_lhb();
        test_back_to_back();
        test_r0_reserved();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
